// File: rtl/clk_div_sequencer.sv
// Steps a counter-based clock divider through a small table of division values.
// Latency: start -> busy next cycle; first tick of a step after div+1 cycles in it.
// No backpressure: start/stop/loads sampled every cycle; loads and start ignored in RUN.
// Optional CLK_DIV_SEQ_LOOP_EN: wrap to step 0 forever instead of entering DONE.
module clk_div_sequencer #(
    parameter int          CNT_W            = 32,
    parameter int          NUM_STEPS        = 4,
    parameter int          TOGGLES_PER_STEP = 2,
    parameter int unsigned DEFAULT_DIV      = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         load_we,
    input  logic [$clog2(NUM_STEPS)-1:0] load_addr,
    input  logic [CNT_W-1:0]             load_data,
    output logic                         divided_clk,
    output logic                         tick,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx
);

    localparam int IDX_W = $clog2(NUM_STEPS);
    localparam int TGL_W = $clog2(TOGGLES_PER_STEP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [TGL_W-1:0]   tgl_q;
    logic [IDX_W-1:0]   step_q;
    logic               fin_q;
    logic               div_clk_q;
    logic               tick_q;
    logic [IDX_W-1:0]   step_idx_q;
    logic [CNT_W-1:0]   div_tbl [NUM_STEPS];

    logic               launch;
    logic               hit;
    logic               step_end;
    logic               last_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        hit       = 1'b0;
        step_end  = 1'b0;
        last_step = (step_q == IDX_W'(NUM_STEPS - 1));
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    launch  = 1'b1;
                end
            end
            S_RUN: begin
                // fin_q marks the one cycle between the final tick and DONE
                if (fin_q) begin
                    state_d = S_DONE;
                end else begin
                    hit      = (cnt_q == div_tbl[step_q]);
                    step_end = hit && (tgl_q == TGL_W'(TOGGLES_PER_STEP - 1));
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (stop) begin
            state_d = S_IDLE;
            launch  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            tgl_q      <= '0;
            step_q     <= '0;
            fin_q      <= 1'b0;
            div_clk_q  <= 1'b0;
            tick_q     <= 1'b0;
            step_idx_q <= '0;
        end else begin
            tick_q     <= 1'b0;
            // reported step trails the internal one so it moves the cycle after the tick
            step_idx_q <= step_q;
            if (stop || launch) begin
                cnt_q      <= '0;
                tgl_q      <= '0;
                step_q     <= '0;
                fin_q      <= 1'b0;
                div_clk_q  <= 1'b0;
                step_idx_q <= '0;
            end else if (state_q == S_RUN && !fin_q) begin
                if (hit) begin
                    cnt_q     <= '0;
                    div_clk_q <= ~div_clk_q;
                    tick_q    <= 1'b1;
                    if (step_end) begin
                        tgl_q <= '0;
                        if (last_step) begin
`ifdef CLK_DIV_SEQ_LOOP_EN
                            step_q <= '0;
`else
                            fin_q  <= 1'b1;
`endif
                        end else begin
                            step_q <= step_q + IDX_W'(1);
                        end
                    end else begin
                        tgl_q <= tgl_q + TGL_W'(1);
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                fin_q <= 1'b0;
            end
        end
    end

    // Table only changes outside RUN, so a write alongside start lands before the run reads it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                div_tbl[i] <= CNT_W'(DEFAULT_DIV);
            end
        end else if (load_we && state_q != S_RUN) begin
            div_tbl[load_addr] <= load_data;
        end
    end

    assign divided_clk = div_clk_q;
    assign tick        = tick_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign step_idx    = step_idx_q;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Testbench for clk_div_sequencer: command vectors plus whole-run checks against a tick-schedule model.
module tb_clk_div_sequencer;

    localparam int NS  = 4;
    localparam int TOG = 2;
    localparam int CW  = 32;
    localparam int DEF = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          load_we = 1'b0;
    logic [1:0]    load_addr = '0;
    logic [CW-1:0] load_data = '0;
    logic          divided_clk, tick, busy, done;
    logic [1:0]    step_idx;

    int checks = 0;
    int errors = 0;
    int mdl_tbl [NS];
    int tq [$];
    int exp_end;
    bit loop_mode;

    typedef struct {
        bit         st;
        bit         sp;
        logic [5:0] exp;
    } vec_t;
    vec_t vt [7];

    clk_div_sequencer #(
        .CNT_W(CW), .NUM_STEPS(NS), .TOGGLES_PER_STEP(TOG), .DEFAULT_DIV(DEF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .divided_clk(divided_clk), .tick(tick), .busy(busy), .done(done),
        .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {tick, divided_clk, busy, done, step_idx};
    endfunction

    task automatic chk(input string nm, input int n, input logic [5:0] exp);
        logic [5:0] got;
        got = obs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d tick/clk/busy/done/idx got %b expected %b", nm, n, got, exp);
        end
    endtask

    // Tick offsets (cycles after busy rises) as cumulative half-periods of the table.
    task automatic build_model(input int horizon);
        int t;
        t = 0;
        tq.delete();
        for (int i = 0; i < 100000; i++) begin
            if (!loop_mode && i >= NS * TOG) break;
            if (loop_mode && t > horizon) break;
            t += mdl_tbl[(i / TOG) % NS] + 1;
            tq.push_back(t);
        end
        exp_end = loop_mode ? 32'h3fff_ffff : tq[$] + 1;
    endtask

    function automatic int ticks_le(input int x);
        int c;
        c = 0;
        foreach (tq[i]) if (tq[i] <= x) c++;
        return c;
    endfunction

    function automatic logic [5:0] exp_at(input int n);
        int c, idx;
        bit tk;
        c  = ticks_le(n - 1) / TOG;
        idx = loop_mode ? c % NS : (c > NS - 1 ? NS - 1 : c);
        tk = 1'b0;
        foreach (tq[i]) if (tq[i] == n) tk = 1'b1;
        return {tk, 1'(ticks_le(n) % 2), n < exp_end, n >= exp_end, 2'(idx)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NS; i++) mdl_tbl[i] = DEF;
    endtask

    task automatic load(input int a, input int d);
        load_we = 1'b1; load_addr = 2'(a); load_data = CW'(d);
        @(posedge clk); #1;
        load_we = 1'b0;
        mdl_tbl[a] = d;
    endtask

    // lim < 0 runs to DONE plus two cycles; otherwise the run is truncated and stopped.
    task automatic run(input string nm, input int lim, input int stop_at, input int rst_at,
                       input int inj_at, input bit wr, input int wa, input int wd);
        int last;
        if (wr) begin
            load_we = 1'b1; load_addr = 2'(wa); load_data = CW'(wd);
            mdl_tbl[wa] = wd;
        end
        build_model(lim < 0 ? 0 : lim);
        last = (lim < 0) ? exp_end + 2 : lim;
        start = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n <= last; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            start = 1'b0; load_we = 1'b0;
            chk(nm, n, exp_at(n));
            if (n == stop_at) begin
                stop = 1'b1;
                @(posedge clk); #1;
                stop = 1'b0;
                chk({nm, "_stop"}, n + 1, 6'b0);
                return;
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int i = 0; i < NS; i++) mdl_tbl[i] = DEF;
                chk({nm, "_rst"}, n + 1, 6'b0);
                return;
            end
            if (n == inj_at) begin
                load_we = 1'b1; load_addr = 2'd1; load_data = CW'(7);
                start = 1'b1;
            end
        end
        if (last < exp_end) begin
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
            chk({nm, "_end"}, last + 1, 6'b0);
        end
    endtask

    initial begin
`ifdef CLK_DIV_SEQ_LOOP_EN
        loop_mode = 1'b1;
`else
        loop_mode = 1'b0;
`endif
        vt[0] = '{st: 1'b0, sp: 1'b0, exp: 6'b000000};
        vt[1] = '{st: 1'b1, sp: 1'b1, exp: 6'b000000};
        vt[2] = '{st: 1'b0, sp: 1'b1, exp: 6'b000000};
        vt[3] = '{st: 1'b1, sp: 1'b0, exp: 6'b001000};
        vt[4] = '{st: 1'b1, sp: 1'b0, exp: 6'b001000};
        vt[5] = '{st: 1'b0, sp: 1'b1, exp: 6'b000000};
        vt[6] = '{st: 1'b0, sp: 1'b0, exp: 6'b000000};

        do_reset();
        chk("reset", 0, 6'b0);

        for (int i = 0; i < 7; i++) begin
            start = vt[i].st; stop = vt[i].sp;
            @(posedge clk); #1;
            start = 1'b0; stop = 1'b0;
            chk("vec", i, vt[i].exp);
        end

        if (loop_mode) begin
            for (int s = 0; s < NS; s++) load(s, 1);
            run("loop", 50, -1, -1, -1, 1'b0, 0, 0);
        end else begin
            run("defaults", -1, -1, -1, -1, 1'b0, 0, 0);
            for (int s = 0; s < NS; s++) load(s, s);
            run("seq0123", -1, -1, -1, -1, 1'b0, 0, 0);
            run("run_write", -1, -1, -1, 1, 1'b0, 0, 0);
            run("after_write", -1, -1, -1, -1, 1'b0, 0, 0);
            run("stop_mid", -1, 10, -1, -1, 1'b0, 0, 0);

            start = 1'b1; stop = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; stop = 1'b0;
            chk("start_stop_idle", 0, 6'b0);

            run("rst_mid", -1, -1, 5, -1, 1'b0, 0, 0);
            run("post_rst", 1003, -1, -1, -1, 1'b0, 0, 0);

            for (int r = 0; r < 4; r++) begin
                for (int s = 0; s < NS; s++) load(s, int'($urandom_range(0, 12)));
                run("random", -1, -1, -1, -1, 1'b1,
                    int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 12)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
